// File: rtl/wb_init_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_init_pkg
// Purpose  : Shared FSM state type and width constants for the Wishbone initiator.
// Revision : 1.0 - initial release
// ============================================================================
package wb_init_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;
  localparam int TIMEOUT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } wb_state_e;

endpackage : wb_init_pkg
`default_nettype wire

// File: rtl/wb_ack_timer.sv
`default_nettype none
// ============================================================================
// Module   : wb_ack_timer
// Purpose  : Loadable saturating counter with clear, enable and terminal flag.
// Revision : 1.0 - initial release
// ============================================================================
module wb_ack_timer
  import wb_init_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_value,
  input  logic [TIMEOUT_W-1:0] terminal,
  output logic                 terminal_hit
);

  logic [TIMEOUT_W-1:0] r_count;

  // Saturating so a long wait can never wrap back below the terminal value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (enable && (r_count != '1)) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

  assign terminal_hit = (r_count == terminal);

endmodule : wb_ack_timer
`default_nettype wire

// File: rtl/wb_simple_initiator.sv
`default_nettype none
// ============================================================================
// Module   : wb_simple_initiator
// Purpose  : Single-outstanding Wishbone pipelined initiator with ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wb_simple_initiator
  import wb_init_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [DATA_W-1:0] i_wb_data
);

  localparam logic [TIMEOUT_W-1:0] C_TERMINAL = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e         r_state;
  wb_state_e         w_next_state;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_timeout;
  logic              w_cmd_fire;
  logic              w_accept;
  logic              w_complete;
  logic              w_abort;
  logic              w_tc;

  assign cmd_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_RESP);
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_accept   = (r_state == ST_STROBE) && !i_wb_stall;
  // An ack coinciding with the terminal count still counts as a completion
  assign w_complete = i_wb_ack && (w_accept || (r_state == ST_WAIT_ACK));
  assign w_abort    = (r_state == ST_WAIT_ACK) && !i_wb_ack && w_tc;

  wb_ack_timer u_ack_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (r_state == ST_STROBE),
    .enable       (r_state == ST_WAIT_ACK),
    .load         (1'b0),
    .load_value   ({TIMEOUT_W{1'b0}}),
    .terminal     (C_TERMINAL),
    .terminal_hit (w_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (w_cmd_fire) w_next_state = ST_STROBE;
      ST_STROBE:   if (!i_wb_stall) w_next_state = i_wb_ack ? ST_RESP : ST_WAIT_ACK;
      ST_WAIT_ACK: if (i_wb_ack || w_tc) w_next_state = ST_RESP;
      ST_RESP:     if (rsp_ready) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Bus address/data/we keep their last value while idle; cyc/stb qualify them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_cyc   <= 1'b1;
        r_stb   <= 1'b1;
        r_we    <= cmd_we;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      if (w_accept) r_stb <= 1'b0;
      if (w_complete) begin
        r_cyc     <= 1'b0;
        r_rdata   <= r_we ? '0 : i_wb_data;
        r_timeout <= 1'b0;
      end else if (w_abort) begin
        r_cyc     <= 1'b0;
        r_rdata   <= '0;
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_addr   = r_addr;
  assign o_wb_data   = r_wdata;
  assign rsp_rdata   = r_rdata;
  assign rsp_timeout = r_timeout;

endmodule : wb_simple_initiator
`default_nettype wire

// File: doc/wb_simple_initiator.md
Name: wb_simple_initiator

Overview:
- Single-outstanding Wishbone pipelined-mode initiator (bus master) that turns a valid/ready command port into one bus read or write, then returns a response.
- Drives the same bus that user-area responders (LED/button peripheral, other `user_params.svh` address decodes) answer on. Lets an internal sequencer or test controller poll buttons and drive LEDs without a CPU.
- Includes a bounded ack timeout, so an unmapped address cannot hang the bus.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width.
- TIMEOUT_CYCLES, 255, cycles to wait for ack after strobe acceptance before aborting; legal range 1..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous assert, active-low reset; release synchronous to clk externally.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  bus address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  transaction aborted by timeout.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  1  strobe.
- o_wb_we  out  1  write enable.
- o_wb_addr  out  ADDR_W  address.
- o_wb_data  out  DATA_W  write data.
- i_wb_ack  in  1  responder ack.
- i_wb_stall  in  1  responder cannot accept strobe.
- i_wb_data  in  DATA_W  responder read data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: all outputs 0 except cmd_ready.
  - cmd_ready = 1 (combinational from state IDLE).
  - Counters and state: timeout counter = 0, state = IDLE.
- Reset mid-transaction: cyc/stb drop immediately, any pending response is discarded, no ack is tracked after release.
- FSM states: IDLE, STROBE, WAIT_ACK, RESP.
- IDLE:
  - cmd_ready = 1.
  - On a cmd handshake: latch we/addr/wdata into o_wb_*, set cyc = stb = 1, go to STROBE.
  - Bus outputs change on the clock edge after the handshake.
- STROBE:
  - Hold cyc = stb = 1 and hold addr/we/data stable while i_wb_stall = 1. There is no timeout while stalled.
  - When stall = 0, the strobe is accepted this cycle: next cycle stb = 0.
  - If ack is also high in that acceptance cycle, treat it as completion.
  - Otherwise go to WAIT_ACK with the counter cleared.
- WAIT_ACK:
  - cyc = 1, stb = 0; the counter increments each cycle.
  - On i_wb_ack: capture i_wb_data when the command was a read (0 for a write), rsp_timeout = 0, cyc = 0, go to RESP.
  - When the counter reaches TIMEOUT_CYCLES - 1 with no ack: cyc = 0, rsp_rdata = 0, rsp_timeout = 1, go to RESP.
  - An ack arriving in the same cycle the timeout fires wins: normal completion.
- Acks seen in IDLE, or in STROBE before acceptance, are ignored.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_timeout are stable until the handshake.
  - On rsp_ready go to IDLE; cmd_ready is asserted the following cycle. There is no command/response overlap.
- Latency with a zero-stall, next-cycle-ack responder:
  - cmd handshake at cycle N; stb high in N+1; ack at N+2; rsp_valid at N+3.
  - Minimum back-to-back period is 4 cycles.
- Width rules: DATA_W/ADDR_W are passed through unmodified. The counter is 16 bits and saturates; it never wraps within a transaction.
- o_wb_we/addr/data hold their last value while idle. Responders must qualify them with cyc && stb.

Decomposition:
- Shared package wb_init_pkg holds:
  - the FSM state enum (2 bits);
  - the default widths;
  - a TIMEOUT_W = 16 constant.
- Address constants stay in `user_params.svh`.
- One natural sub-module: wb_ack_timer, a loadable saturating counter with clear, enable, and a terminal-count flag.

Test Plan:
- LED write, no stall, ack next cycle:
  - Stimulus: cmd we=1, addr=LED_ADDRESS, wdata=0x2.
  - Required: stb high exactly 1 cycle with we=1 and data=0x2; rsp_valid 3 cycles after the handshake with rdata=0, timeout=0.
- Button read:
  - Stimulus: responder returns 0x00000001 with the ack.
  - Required: rsp_rdata=0x00000001; cyc low in the RESP cycle.
- Stall:
  - Stimulus: hold i_wb_stall=1 for 5 cycles.
  - Required: stb, addr and we stable for 6 cycles; stb drops after the first stall-free cycle; no timeout.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, responder never acks.
  - Required: cyc falls 8 cycles after acceptance; rsp_timeout=1, rdata=0; the next command is accepted normally.
- Backpressure and boundaries:
  - Stimulus: rsp_ready low for 10 cycles, then high.
  - Required: cmd_ready stays 0 and the response is stable throughout.
  - Stimulus: ack at the timeout cycle. Required: normal completion with timeout=0.
- Async reset in WAIT_ACK:
  - Stimulus: pulse reset_n low mid-cycle.
  - Required: cyc=0 immediately, with no clock edge needed; cmd_ready=1; no rsp_valid after release even if a stale ack arrives.
